// File: rtl/rv_alu_md.sv
// rv_alu_md: execute-stage ALU, RV32I/RV64I base ops + M-extension mul/div.
// Ports: clk, rst_n, in_valid/in_ready, op, a, b, flush -> out_valid, y, busy.
module rv_alu_md #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] y,
    output logic            busy
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLT    = 5'd2;
    localparam logic [4:0] OP_SLTU   = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_OR     = 5'd5;
    localparam logic [4:0] OP_AND    = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_EQ     = 5'd10;
    localparam logic [4:0] OP_NEQ    = 5'd11;
    localparam logic [4:0] OP_GE     = 5'd12;
    localparam logic [4:0] OP_GEU    = 5'd13;
    localparam logic [4:0] OP_MUL    = 5'd14;
    localparam logic [4:0] OP_MULH   = 5'd15;
    localparam logic [4:0] OP_MULHSU = 5'd16;
    localparam logic [4:0] OP_MULHU  = 5'd17;
    localparam logic [4:0] OP_DIV    = 5'd18;
    localparam logic [4:0] OP_DIVU   = 5'd19;
    localparam logic [4:0] OP_REM    = 5'd20;
    localparam logic [4:0] OP_REMU   = 5'd21;

    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    logic [4:0]        op_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   bm;
    logic [SHW-1:0]    cnt;
    logic              neg_p;
    logic              neg_a;

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [SHW-1:0]  sh;
    logic            is_mul;
    logic            is_div;
    logic            sgn_a;
    logic            sgn_b;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] y_alu;
    logic [XLEN-1:0] y_spec;
    logic [XLEN-1:0] y_md;

    assign a_s = $signed(a);
    assign b_s = $signed(b);
    assign sh  = b[SHW-1:0];

    assign in_ready = (state == S_IDLE) && !flush;
    assign busy     = (state != S_IDLE);

    assign is_mul = (op >= OP_MUL) && (op <= OP_MULHU);
    assign is_div = (op >= OP_DIV) && (op <= OP_REMU);
    assign sgn_a  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU)
                 || (op == OP_DIV) || (op == OP_REM);
    assign sgn_b  = (op == OP_MUL) || (op == OP_MULH)
                 || (op == OP_DIV) || (op == OP_REM);
    assign a_neg  = sgn_a && a[XLEN-1];
    assign b_neg  = sgn_b && b[XLEN-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    // Divide-by-zero and signed overflow finish at accept, no iteration.
    assign div_zero = (b == '0);
    assign div_ovf  = ((op == OP_DIV) || (op == OP_REM))
                   && (a == MINV) && (b == '1);
    assign y_spec   = ((op == OP_DIV) || (op == OP_DIVU))
                    ? (div_zero ? '1 : a)
                    : (div_zero ? a : '0);

    always_comb begin
        y_alu = '0;
        case (op)
            OP_ADD:  y_alu = a + b;
            OP_SUB:  y_alu = a - b;
            OP_SLT:  y_alu = XLEN'(a_s < b_s);
            OP_SLTU: y_alu = XLEN'(a < b);
            OP_XOR:  y_alu = a ^ b;
            OP_OR:   y_alu = a | b;
            OP_AND:  y_alu = a & b;
            OP_SLL:  y_alu = a << sh;
            OP_SRL:  y_alu = a >> sh;
            OP_SRA:  y_alu = $unsigned(a_s >>> sh);
            OP_EQ:   y_alu = XLEN'(a == b);
            OP_NEQ:  y_alu = XLEN'(a != b);
            OP_GE:   y_alu = XLEN'(a_s >= b_s);
            OP_GEU:  y_alu = XLEN'(a >= b);
            default: y_alu = '0;
        endcase
    end

    // Shift-add: acc = {partial, multiplier}; add on the multiplier LSB.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    // Restoring divide: acc = {remainder, dividend/quotient}.
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, bm};
    assign mul_next = acc[0]
                    ? {mul_sum, acc[XLEN-1:1]}
                    : {1'b0, acc[2*XLEN-1:1]};

    assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, bm};
    assign div_next  = div_trial[XLEN]
                     ? {acc[2*XLEN-2:0], 1'b0}
                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qv;
    logic [XLEN-1:0]   rv;

    assign prod = neg_p ? -acc : acc;
    assign qv   = neg_p ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rv   = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        y_md = '0;
        case (op_q)
            OP_MUL:    y_md = prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  y_md = prod[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:   y_md = qv;
            OP_REM,
            OP_REMU:   y_md = rv;
            default:   y_md = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            acc       <= '0;
            bm        <= '0;
            cnt       <= '0;
            neg_p     <= 1'b0;
            neg_a     <= 1'b0;
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (in_valid) begin
                            op_q  <= op;
                            cnt   <= '0;
                            neg_p <= a_neg ^ b_neg;
                            neg_a <= a_neg;
                            if (is_mul) begin
                                acc   <= {{XLEN{1'b0}}, b_mag};
                                bm    <= a_mag;
                                state <= S_MUL;
                            end else if (is_div && !div_zero && !div_ovf) begin
                                acc   <= {{XLEN{1'b0}}, a_mag};
                                bm    <= b_mag;
                                state <= S_DIV;
                            end else begin
                                y         <= is_div ? y_spec : y_alu;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                    S_MUL: begin
                        acc <= mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == SHW'(XLEN-1)) state <= S_DONE;
                    end
                    S_DIV: begin
                        acc <= div_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == SHW'(XLEN-1)) state <= S_DONE;
                    end
                    S_DONE: begin
                        y         <= y_md;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rv_alu_md.md
Name: rv_alu_md

Overview:
- Parametrised execute-stage ALU, successor to the single-cycle RV32I ALU.
- Adds the RISC-V M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Base ops complete in one cycle. Multiply and divide run iteratively over multiple cycles.
- Sits between decode/operand-forwarding and writeback. A valid/ready handshake lets the pipeline stall on long operations.

Parameters:
- XLEN, 32, datapath width. Legal values are 32 or 64.
- SHW, $clog2(XLEN), shift-amount width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an op this cycle
- op  in  5  operation code (see Behaviour)
- a  in  XLEN  rs1 or pc
- b  in  XLEN  rs2 or imm
- flush  in  1  abort any in-flight op (pipeline flush)
- out_valid  out  1  single-cycle pulse: y holds a new result
- y  out  XLEN  registered result
- busy  out  1  multi-cycle op in progress

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND
  - 7 SLL, 8 SRL, 9 SRA
  - 10 EQ, 11 NEQ, 12 GE, 13 GEU
  - 14 MUL, 15 MULH, 16 MULHSU, 17 MULHU
  - 18 DIV, 19 DIVU, 20 REM, 21 REMU
  - 22-31 are reserved and produce y=0 with single-cycle latency.
- Accept: an op is accepted when in_valid && in_ready. in_ready = (state==IDLE) && !flush.
- Compare ops (2, 3, 10-13) return 0 or 1, zero-extended. Signed compares use two's complement.
- Shifts use b[SHW-1:0]. SRA fills with a[XLEN-1].
- State machine: IDLE, MUL, DIV, DONE.
- Ops 0-13, reserved ops, and div/rem special cases:
  - Accepted at cycle T; y is registered at the edge ending T; out_valid=1 during T+1.
  - The FSM stays in IDLE, so back-to-back single-cycle ops are accepted every cycle.
- MUL*:
  - IDLE->MUL on accept.
  - Radix-2 shift-add over operand magnitudes, one bit per cycle, XLEN iterations, with a 2*XLEN-bit accumulator.
  - Sign is corrected at DONE per op signedness. MULHSU treats a as signed and b as unsigned.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- DIV*:
  - IDLE->DIV on accept.
  - Restoring division on magnitudes, XLEN iterations.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Multi-cycle latency:
  - Iterations run in cycles T+1..T+XLEN, then MUL/DIV->DONE.
  - DONE lasts one cycle (sign fix and y register).
  - out_valid=1 during T+XLEN+2. The FSM returns to IDLE in that same cycle, so in_ready=1 there.
- busy = (state != IDLE).
- Division special cases, resolved at accept with single-cycle latency:
  - b==0: DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow, a=-2^(XLEN-1) with b=-1: DIV gives a; REM gives 0.
- flush:
  - Any state -> IDLE at the next edge.
  - No out_valid is issued for the aborted op, and y keeps its last value.
  - flush in the same cycle as in_valid: the op is not accepted.
  - A pending single-cycle out_valid is not suppressed, because it was already registered.
- y holds its value between out_valid pulses.
- Operands a, b and op are captured at accept. Input changes during busy are ignored.
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE; y=0, out_valid=0, busy=0.
  - Accumulators and counter are cleared.
  - in_ready=1 after reset deasserts.

Test Plan:
- ADD 0xFFFFFFFF + 1 -> y=0x00000000, out_valid one cycle later. SRA 0x80000000 >> 4 -> 0xF8000000. SLT(-1, 1) -> 1; SLTU(-1, 1) -> 0.
- Back-to-back stream XOR, OR, AND, GEU on consecutive cycles -> four consecutive out_valid pulses, in_ready never low.
- MULH(0x80000000, 0x80000000) -> 0x40000000, out_valid at T+34 (XLEN=32). in_ready and busy are low T+1..T+33. MULHSU(-1, 2) -> 0xFFFFFFFF.
- DIV(-7, 2) -> -3 (0xFFFFFFFD); REM(-7, 2) -> -1. DIVU(7, 0) -> 0xFFFFFFFF at T+1. REM(0x80000000, -1) -> 0 at T+1.
- Start DIVU, then assert flush at T+10 -> no out_valid, busy low at T+11, y unchanged, and a new ADD is accepted at T+11.
- Assert rst_n low mid-MUL at T+5 -> y=0, out_valid=0 and busy=0 immediately. Repeat with XLEN=64: MUL(2^40, 2^20) -> 2^60 at T+66.
